// File: rtl/csc_rgb2ycbcr_pipe_if.sv
// csc_rgb2ycbcr_pipe_if: AXI-Stream style pixel channel (data/valid/ready/last/user)
//   DATA_W : bits per colour component; tdata carries three components
//   master : drives tdata/tvalid/tlast/tuser, receives tready
//   slave  : receives tdata/tvalid/tlast/tuser, drives tready
interface csc_rgb2ycbcr_pipe_if #(
    parameter int DATA_W = 8
);
    logic [3*DATA_W-1:0] tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic                tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/csc_rgb2ycbcr_pipe.sv
// csc_rgb2ycbcr_pipe: 3-stage back-pressurable RGB->YCbCr converter with bypass/grey modes and saturation stats
//   clk, rst_n   : clock, asynchronous active-low reset
//   cfg_mode     : 0 convert, 1 bypass, 2 grey, 3 convert; sampled on start-of-frame beats only
//   s_axis       : slave pixel stream, tdata = {R, G, B} unsigned
//   m_axis       : master pixel stream, tdata = {Y, Cb, Cr} two's complement, Y level-shifted
//   stat_clr     : synchronous clear of stat_sat_cnt (wins over a same-cycle increment)
//   stat_sat_cnt : saturated-component count, sticks at all-ones
//   Build option CSC_ROUND_EN: when defined, results round half up instead of flooring.
module csc_rgb2ycbcr_pipe #(
    parameter int DATA_W = 8,
    parameter int STAT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             cfg_mode,
    csc_rgb2ycbcr_pipe_if.slave    s_axis,
    csc_rgb2ycbcr_pipe_if.master   m_axis,
    input  logic                   stat_clr,
    output logic [STAT_W-1:0]      stat_sat_cnt
);
    localparam int W    = DATA_W;
    localparam int SW   = DATA_W + 11;
    localparam int HALF = 1 << (DATA_W - 1);
`ifdef CSC_ROUND_EN
    localparam int RND = 128;
`else
    localparam int RND = 0;
`endif

    localparam logic signed [SW-1:0] KYR   = SW'(77);
    localparam logic signed [SW-1:0] KYG   = SW'(150);
    localparam logic signed [SW-1:0] KYB   = SW'(29);
    localparam logic signed [SW-1:0] KBR   = SW'(-43);
    localparam logic signed [SW-1:0] KBG   = SW'(-85);
    localparam logic signed [SW-1:0] KBB   = SW'(128);
    localparam logic signed [SW-1:0] KRR   = SW'(128);
    localparam logic signed [SW-1:0] KRG   = SW'(-107);
    localparam logic signed [SW-1:0] KRB   = SW'(-21);
    localparam logic signed [SW-1:0] RNDV  = SW'(RND);
    localparam logic signed [SW-1:0] HALFV = SW'(HALF);
    localparam logic signed [SW-1:0] MAXV  = SW'(HALF - 1);
    localparam logic signed [SW-1:0] MINV  = SW'(-HALF);

    typedef enum logic [1:0] {M_CONV = 2'd0, M_BYP = 2'd1, M_GREY = 2'd2, M_RSV = 2'd3} mode_e;

    // {saturated flag, clamped W-bit result}
    function automatic logic [W:0] sat(input logic signed [SW-1:0] x);
        return (x > MAXV) ? {1'b1, MAXV[W-1:0]} : (x < MINV) ? {1'b1, MINV[W-1:0]} : {1'b0, x[W-1:0]};
    endfunction

    logic                   en, s_fire;
    mode_e                  mode_q, mode_d, mode_in, mode_eff;
    logic                   v1_q, l1_q, u1_q;
    logic [3*W-1:0]         px1_q;
    mode_e                  md1_q;
    logic                   v2_q, l2_q, u2_q;
    logic [3*W-1:0]         px2_q;
    mode_e                  md2_q;
    logic signed [SW-1:0]   ys_q, cbs_q, crs_q, ys_d, cbs_d, crs_d;
    logic signed [SW-1:0]   r, g, b, yt, cbt, crt;
    logic [W:0]             ysat, cbsat, crsat;
    logic                   mv_q, ml_q, mu_q;
    logic [3*W-1:0]         md_q, md_d;
    logic [1:0]             inc;
    logic [STAT_W:0]        cnt_sum;
    logic [STAT_W-1:0]      cnt_q, cnt_d;

    // The whole pipe moves together; it only freezes when a held output beat is refused.
    assign en            = m_axis.tready | ~mv_q;
    assign s_fire        = s_axis.tvalid & en;
    assign s_axis.tready = en;
    assign m_axis.tvalid = mv_q;
    assign m_axis.tlast  = ml_q;
    assign m_axis.tuser  = mu_q;
    assign m_axis.tdata  = md_q;
    assign stat_sat_cnt  = cnt_q;

    always_comb begin
        mode_in  = (cfg_mode == 2'd3) ? M_CONV : mode_e'(cfg_mode);
        // A start-of-frame beat uses the new mode itself; every other beat uses the latched one.
        mode_eff = s_axis.tuser ? mode_in : mode_q;
        mode_d   = (s_fire && s_axis.tuser) ? mode_in : mode_q;
        r        = {{11{1'b0}}, px1_q[3*W-1:2*W]};
        g        = {{11{1'b0}}, px1_q[2*W-1:W]};
        b        = {{11{1'b0}}, px1_q[W-1:0]};
        ys_d     = KYR * r + KYG * g + KYB * b;
        cbs_d    = KBR * r + KBG * g + KBB * b;
        crs_d    = KRR * r + KRG * g + KRB * b;
        yt       = ((ys_q + RNDV) >>> 8) - HALFV;
        cbt      = (cbs_q + RNDV) >>> 8;
        crt      = (crs_q + RNDV) >>> 8;
        ysat     = sat(yt);
        cbsat    = sat(cbt);
        crsat    = sat(crt);
        md_d     = (md2_q == M_BYP)  ? px2_q :
                   (md2_q == M_GREY) ? {ysat[W-1:0], {(2*W){1'b0}}} :
                                       {ysat[W-1:0], cbsat[W-1:0], crsat[W-1:0]};
        inc      = (md2_q == M_BYP)  ? 2'd0 :
                   (md2_q == M_GREY) ? 2'(ysat[W]) :
                                       2'(ysat[W]) + 2'(cbsat[W]) + 2'(crsat[W]);
        cnt_sum  = {1'b0, cnt_q} + {{(STAT_W-1){1'b0}}, inc};
        cnt_d    = stat_clr ? '0 :
                   (en && v2_q) ? (cnt_sum[STAT_W] ? '1 : cnt_sum[STAT_W-1:0]) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= M_CONV;
            cnt_q  <= '0;
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
            u1_q   <= 1'b0;
            px1_q  <= '0;
            md1_q  <= M_CONV;
            v2_q   <= 1'b0;
            l2_q   <= 1'b0;
            u2_q   <= 1'b0;
            px2_q  <= '0;
            md2_q  <= M_CONV;
            ys_q   <= '0;
            cbs_q  <= '0;
            crs_q  <= '0;
            mv_q   <= 1'b0;
            ml_q   <= 1'b0;
            mu_q   <= 1'b0;
            md_q   <= '0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            if (en) begin
                v1_q  <= s_axis.tvalid;
                l1_q  <= s_axis.tlast;
                u1_q  <= s_axis.tuser;
                px1_q <= s_axis.tdata;
                md1_q <= mode_eff;
                v2_q  <= v1_q;
                l2_q  <= l1_q;
                u2_q  <= u1_q;
                px2_q <= px1_q;
                md2_q <= md1_q;
                ys_q  <= ys_d;
                cbs_q <= cbs_d;
                crs_q <= crs_d;
                mv_q  <= v2_q;
                ml_q  <= l2_q;
                mu_q  <= u2_q;
                md_q  <= md_d;
            end
        end
    end
endmodule

// File: tb/tb_csc_rgb2ycbcr_pipe.sv
// tb_csc_rgb2ycbcr_pipe: directed and randomized check of csc_rgb2ycbcr_pipe against an arithmetic model
module tb_csc_rgb2ycbcr_pipe;
`ifdef CSC_ROUND_EN
    localparam int RND = 128;
    localparam logic [23:0] RED_O = 24'hCDD57F, BLUE_O = 24'h9D7FEB, RED_GREY = 24'hCD0000;
    localparam int RED_N = 1, BLUE_N = 1;
`else
    localparam int RND = 0;
    localparam logic [23:0] RED_O = 24'hCCD57F, BLUE_O = 24'h9C7FEB, RED_GREY = 24'hCC0000;
    localparam int RED_N = 0, BLUE_N = 0;
`endif
    localparam int CMAX = 63;

    typedef struct packed {logic [23:0] d; logic l; logic u;} beat_t;

    logic       clk = 0, rst_n = 0, stat_clr = 0;
    logic [1:0] cfg_mode = 0;
    logic [5:0] stat_sat_cnt;
    int         n_chk = 0, n_fail = 0, exp_cnt = 0;
    logic [1:0] bmode = 0;
    beat_t      q[$];
    bit         rnd_ready = 0, held = 0;
    beat_t      h;

    csc_rgb2ycbcr_pipe_if #(.DATA_W(8)) s_if ();
    csc_rgb2ycbcr_pipe_if #(.DATA_W(8)) m_if ();

    csc_rgb2ycbcr_pipe #(.DATA_W(8), .STAT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .s_axis(s_if), .m_axis(m_if),
        .stat_clr(stat_clr), .stat_sat_cnt(stat_sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int fl8(input int a);
        return (a >= 0) ? a / 256 : -((-a + 255) / 256);
    endfunction

    function automatic logic [8:0] sat9(input int v);
        if (v > 127) return {1'b1, 8'h7f};
        if (v < -128) return {1'b1, 8'h80};
        return {1'b0, 8'(v)};
    endfunction

    task automatic ref_beat(input logic [23:0] px, input logic [1:0] md, output logic [23:0] o, output int ns);
        int r, g, b;
        logic [8:0] y, cb, cr;
        r  = int'(px[23:16]);
        g  = int'(px[15:8]);
        b  = int'(px[7:0]);
        y  = sat9(fl8(77 * r + 150 * g + 29 * b + RND) - 128);
        cb = sat9(fl8(-43 * r - 85 * g + 128 * b + RND));
        cr = sat9(fl8(128 * r - 107 * g - 21 * b + RND));
        if (md == 2'd1) begin
            o = px; ns = 0;
        end else if (md == 2'd2) begin
            o = {y[7:0], 16'h0}; ns = int'(y[8]);
        end else begin
            o = {y[7:0], cb[7:0], cr[7:0]}; ns = int'(y[8]) + int'(cb[8]) + int'(cr[8]);
        end
    endtask

    // input side: every accepted beat produces one expected output beat
    always @(negedge clk) begin
        logic [1:0] md;
        logic [23:0] o;
        int ns;
        if (rst_n && s_if.tvalid && s_if.tready) begin
            md = s_if.tuser ? cfg_mode : bmode;
            if (s_if.tuser) bmode = md;
            ref_beat(s_if.tdata, md, o, ns);
            q.push_back('{d: o, l: s_if.tlast, u: s_if.tuser});
            exp_cnt = (exp_cnt + ns > CMAX) ? CMAX : exp_cnt + ns;
        end
    end

    // output side: compare each delivered beat, and hold stability across stalls
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) held = 0;
        else begin
            if (held) begin
                chk("stall tvalid", m_if.tvalid, 1);
                chk("stall tdata", m_if.tdata, h.d);
                chk("stall tlast", m_if.tlast, h.l);
                chk("stall tuser", m_if.tuser, h.u);
            end
            held = 0;
            if (m_if.tvalid) begin
                if (m_if.tready) begin
                    if (q.size() == 0) chk("beat expected", q.size(), 1);
                    else begin
                        e = q.pop_front();
                        chk("out tdata", m_if.tdata, e.d);
                        chk("out tlast", m_if.tlast, e.l);
                        chk("out tuser", m_if.tuser, e.u);
                    end
                end else begin
                    held = 1;
                    h = '{d: m_if.tdata, l: m_if.tlast, u: m_if.tuser};
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) m_if.tready = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] px, input bit u, input bit l, input logic [1:0] md);
        bit acc = 0;
        s_if.tdata = px; s_if.tuser = u; s_if.tlast = l; cfg_mode = md; s_if.tvalid = 1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = s_if.tready;
            tick;
        end
        if (!acc) chk("accept timeout", acc, 1);
        s_if.tvalid = 0;
    endtask

    task automatic direct(input logic [23:0] px, input bit u, input bit l, input logic [1:0] md,
                          input logic [23:0] exp, input string nm);
        int lat = 1;
        push(px, u, l, md);
        while (!m_if.tvalid && lat < 10) begin
            tick;
            lat++;
        end
        chk({nm, " latency"}, lat, 3);
        chk({nm, " data"}, m_if.tdata, exp);
        chk({nm, " tlast"}, m_if.tlast, l);
        chk({nm, " tuser"}, m_if.tuser, u);
        repeat (2) tick;
    endtask

    function automatic logic [7:0] rc;
        return ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 8'hff : 8'h00) : 8'($urandom_range(0, 255));
    endfunction

    initial begin
        s_if.tvalid = 0; s_if.tdata = 0; s_if.tlast = 0; s_if.tuser = 0; m_if.tready = 1;
        repeat (2) tick;
        chk("reset tvalid", m_if.tvalid, 0);
        chk("reset tdata", m_if.tdata, 0);
        chk("reset tlast", m_if.tlast, 0);
        chk("reset tuser", m_if.tuser, 0);
        chk("reset count", stat_sat_cnt, 0);
        chk("reset s_tready", s_if.tready, 1);
        rst_n = 1;
        tick;

        direct(24'hFFFFFF, 1, 0, 0, 24'h7F0000, "white");
        chk("white count", stat_sat_cnt, 0);
        direct(24'h000000, 0, 0, 0, 24'h800000, "black");
        direct(24'hFF0000, 0, 0, 0, RED_O, "red");
        chk("red count", stat_sat_cnt, RED_N);
        direct(24'h0000FF, 0, 1, 0, BLUE_O, "blue");
        chk("blue count", stat_sat_cnt, RED_N + BLUE_N);
        chk("model count", stat_sat_cnt, exp_cnt);

        // clear lands on the very edge where a saturating red beat would increment
        s_if.tdata = 24'hFF0000; s_if.tuser = 0; s_if.tlast = 0; s_if.tvalid = 1;
        tick;
        s_if.tvalid = 0;
        tick;
        stat_clr = 1;
        tick;
        stat_clr = 0;
        repeat (2) tick;
        chk("clear priority count", stat_sat_cnt, 0);
        exp_cnt = 0;

        direct(24'hFFFFFF, 1, 0, 1, 24'hFFFFFF, "A0 bypass");
        direct(24'hFF0000, 0, 0, 2, 24'hFF0000, "A1 bypass");
        direct(24'h0000FF, 0, 1, 2, 24'h0000FF, "A2 bypass");
        direct(24'hFFFFFF, 1, 0, 2, 24'h7F0000, "B0 grey");
        direct(24'hFF0000, 0, 1, 0, RED_GREY, "B1 grey");
        chk("bypass/grey count", stat_sat_cnt, 0);
        direct(24'h0000FF, 1, 1, 3, BLUE_O, "mode3 as convert");
        chk("mode3 count", stat_sat_cnt, BLUE_N);

        rnd_ready = 1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) tick;
            push({rc(), rc(), rc()}, (i % 50) == 0, (i % 10) == 9, 2'($urandom_range(0, 3)));
        end
        rnd_ready = 0;
        tick;
        m_if.tready = 1;
        for (int t = 0; t < 100 && q.size() != 0; t++) tick;
        chk("drain queue", q.size(), 0);
        repeat (2) tick;
        chk("random count", stat_sat_cnt, exp_cnt);

        m_if.tready = 0;
        push(24'h102030, 1, 0, 1);
        push(24'h405060, 0, 0, 1);
        push(24'h708090, 0, 1, 1);
        chk("pre-reset tvalid", m_if.tvalid, 1);
        rst_n = 0;
        #1;
        chk("reset mid tvalid", m_if.tvalid, 0);
        chk("reset mid count", stat_sat_cnt, 0);
        q.delete();
        bmode = 0;
        exp_cnt = 0;
        repeat (2) tick;
        m_if.tready = 1;
        rst_n = 1;
        for (int t = 0; t < 5; t++) begin
            tick;
            chk("no stale beat", m_if.tvalid, 0);
        end
        direct(24'hFFFFFF, 0, 0, 1, 24'h7F0000, "post-reset mode");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
